count_tracker: RTL and testbench

COUNT_TRACKER -- requirements
Module: count_tracker

---
 rtl/count_tracker_pkg.sv | 27 ++
 rtl/count_delta.sv | 39 +++
 rtl/count_tracker.sv | 158 +++++++++++++++
 tb/tb_count_tracker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_tracker_pkg.sv
// Shared definitions for the count_tracker block: state encoding, delta classes,
// default widths.
package count_tracker_pkg;

  localparam int unsigned DefaultCw    = 6;
  localparam int unsigned DefaultStepw = 8;

  typedef enum logic [2:0] {
    StEmpty = 3'd0,
    StPrime = 3'd1,
    StUp    = 3'd2,
    StDown  = 3'd3,
    StFault = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DcZero,
    DcPlus,
    DcMinus,
    DcIllegal
  } delta_class_e;

  function automatic logic is_locked(input state_e s);
    return (s == StUp) || (s == StDown);
  endfunction

endpackage

// File: rtl/count_delta.sv
// Modular difference between a new count sample and the previous one,
// classified as zero, +1, -1 or illegal, plus a flag for a legal step across zero.
module count_delta
  import count_tracker_pkg::*;
#(
  parameter int unsigned CW = DefaultCw
) (
  input  logic [CW-1:0] i_count,
  input  logic [CW-1:0] i_prev,
  output delta_class_e  o_class,
  output logic          o_wrap
);

  logic [CW-1:0] w_delta;

  assign w_delta = i_count - i_prev;

  always_comb begin
    o_class = DcIllegal;
    if (w_delta == '0) begin
      o_class = DcZero;
    end else if (w_delta == CW'(1)) begin
      o_class = DcPlus;
    end else if (w_delta == '1) begin
      o_class = DcMinus;
    end
  end

  // Up step landing on 0 came from all-ones; down step landing on all-ones came from 0.
  always_comb begin
    o_wrap = 1'b0;
    if (o_class == DcPlus && i_count == '0) begin
      o_wrap = 1'b1;
    end else if (o_class == DcMinus && i_count == '1) begin
      o_wrap = 1'b1;
    end
  end

endmodule

// File: rtl/count_tracker.sv
// Observes samples of an up/down counter, infers its direction and reports wraps,
// reversals, illegal jumps and the current same-direction run length.
module count_tracker
  import count_tracker_pkg::*;
#(
  parameter int unsigned CW    = DefaultCw,
  parameter int unsigned STEPW = DefaultStepw
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [CW-1:0]    count_in,
  input  logic             count_valid,
  output logic             dir_out,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             rev_pulse,
  output logic             err_pulse,
  output logic [STEPW-1:0] step_cnt,
  output logic [2:0]       state
);

  state_e             r_state;
  logic [CW-1:0]      r_prev;
  logic               r_dir;
  logic               r_locked;
  logic               r_wrap;
  logic               r_rev;
  logic               r_err;
  logic [STEPW-1:0]   r_step;

  delta_class_e       w_class;
  logic               w_wrap;
  logic [STEPW-1:0]   w_step_inc;

  count_delta #(
    .CW(CW)
  ) u_count_delta (
    .i_count(count_in),
    .i_prev (r_prev),
    .o_class(w_class),
    .o_wrap (w_wrap)
  );

  assign w_step_inc = (r_step == '1) ? r_step : r_step + STEPW'(1);

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state  <= StEmpty;
      r_prev   <= '0;
      r_dir    <= 1'b0;
      r_locked <= 1'b0;
      r_wrap   <= 1'b0;
      r_rev    <= 1'b0;
      r_err    <= 1'b0;
      r_step   <= '0;
    end else begin
      r_wrap <= 1'b0;
      r_rev  <= 1'b0;
      r_err  <= 1'b0;
      if (count_valid) begin
        r_prev <= count_in;
        unique case (r_state)
          StEmpty: begin
            r_state  <= StPrime;
            r_locked <= 1'b0;
          end
          StPrime: begin
            unique case (w_class)
              DcZero: ;
              DcPlus: begin
                r_state  <= StUp;
                r_dir    <= 1'b0;
                r_locked <= 1'b1;
                r_step   <= STEPW'(1);
                r_wrap   <= w_wrap;
              end
              DcMinus: begin
                r_state  <= StDown;
                r_dir    <= 1'b1;
                r_locked <= 1'b1;
                r_step   <= STEPW'(1);
                r_wrap   <= w_wrap;
              end
              default: begin
                r_state  <= StFault;
                r_locked <= 1'b0;
                r_err    <= 1'b1;
                r_step   <= '0;
              end
            endcase
          end
          StUp: begin
            unique case (w_class)
              DcZero: ;
              DcPlus: begin
                r_step <= w_step_inc;
                r_wrap <= w_wrap;
              end
              DcMinus: begin
                r_state <= StDown;
                r_dir   <= 1'b1;
                r_step  <= STEPW'(1);
                r_rev   <= 1'b1;
                r_wrap  <= w_wrap;
              end
              default: begin
                r_state  <= StFault;
                r_locked <= 1'b0;
                r_err    <= 1'b1;
                r_step   <= '0;
              end
            endcase
          end
          StDown: begin
            unique case (w_class)
              DcZero: ;
              DcMinus: begin
                r_step <= w_step_inc;
                r_wrap <= w_wrap;
              end
              DcPlus: begin
                r_state <= StUp;
                r_dir   <= 1'b0;
                r_step  <= STEPW'(1);
                r_rev   <= 1'b1;
                r_wrap  <= w_wrap;
              end
              default: begin
                r_state  <= StFault;
                r_locked <= 1'b0;
                r_err    <= 1'b1;
                r_step   <= '0;
              end
            endcase
          end
          StFault: begin
            // Resynchronise: this sample becomes the new reference.
            r_state  <= StPrime;
            r_locked <= 1'b0;
          end
          default: begin
            r_state  <= StEmpty;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dir_out    = r_dir;
  assign locked     = r_locked;
  assign wrap_pulse = r_wrap;
  assign rev_pulse  = r_rev;
  assign err_pulse  = r_err;
  assign step_cnt   = r_step;
  assign state      = r_state;

endmodule

// File: tb/tb_count_tracker.sv
// Self-checking bench for count_tracker: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the tracking rules.
module tb_count_tracker;

  localparam int CW     = 6;
  localparam int STEPW  = 8;
  localparam int Mask   = (1 << CW) - 1;
  localparam int SatMax = (1 << STEPW) - 1;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic [CW-1:0]    count_in = '0;
  logic             count_valid = 1'b0;
  logic             dir_out;
  logic             locked;
  logic             wrap_pulse;
  logic             rev_pulse;
  logic             err_pulse;
  logic [STEPW-1:0] step_cnt;
  logic [2:0]       state;

  count_tracker #(
    .CW   (CW),
    .STEPW(STEPW)
  ) u_dut (
    .clock      (clock),
    .rst        (rst),
    .count_in   (count_in),
    .count_valid(count_valid),
    .dir_out    (dir_out),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .rev_pulse  (rev_pulse),
    .err_pulse  (err_pulse),
    .step_cnt   (step_cnt),
    .state      (state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Model: 0 EMPTY, 1 PRIME, 2 UP, 3 DOWN, 4 FAULT
  int m_state = 0, m_prev = 0, m_dir = 0, m_step = 0;
  int m_wrap = 0, m_rev = 0, m_err = 0;
  int wrap_seen = 0;
  int last_x = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input int x);
    int d;
    int nxt;
    if (r) begin
      m_state = 0; m_prev = 0; m_dir = 0; m_step = 0;
      m_wrap = 0; m_rev = 0; m_err = 0;
      return;
    end
    m_wrap = 0; m_rev = 0; m_err = 0;
    if (!v) return;
    d = (x - m_prev) & Mask;
    case (m_state)
      0, 4: m_state = 1;
      default: begin
        if (d == 0) begin
          // no change
        end else if (d == 1 || d == Mask) begin
          nxt = (d == 1) ? 2 : 3;
          m_wrap = (d == 1) ? int'(x == 0) : int'(x == Mask);
          if (m_state != 1 && nxt != m_state) m_rev = 1;
          m_step = (nxt == m_state) ? ((m_step + 1 > SatMax) ? SatMax : m_step + 1) : 1;
          m_dir = (nxt == 3) ? 1 : 0;
          m_state = nxt;
        end else begin
          m_state = 4;
          m_err = 1;
          m_step = 0;
        end
      end
    endcase
    m_prev = x;
  endtask

  task automatic cyc(input bit r, input bit v, input int x, input string tag);
    @(negedge clock);
    rst = r;
    count_valid = v;
    count_in = x[CW-1:0];
    if (v && !r) last_x = x & Mask;
    @(posedge clock);
    #1;
    model(r, v, x & Mask);
    wrap_seen += int'(wrap_pulse === 1'b1);
    check({tag, "/state"}, 32'(state), 32'(m_state));
    check({tag, "/locked"}, 32'(locked), 32'(m_state == 2 || m_state == 3));
    check({tag, "/dir"}, 32'(dir_out), 32'(m_dir));
    check({tag, "/step"}, 32'(step_cnt), 32'(m_step));
    check({tag, "/wrap"}, 32'(wrap_pulse), 32'(m_wrap));
    check({tag, "/rev"}, 32'(rev_pulse), 32'(m_rev));
    check({tag, "/err"}, 32'(err_pulse), 32'(m_err));
  endtask

  task automatic do_reset(input string tag);
    cyc(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, Mask)), tag);
  endtask

  initial begin
    do_reset("rst0");
    check("rst0_state_zero", 32'(state), 32'd0);
    check("rst0_step_zero", 32'(step_cnt), 32'd0);

    // Basic up run
    do_reset("s33r");
    cyc(0, 1, 5, "s33a");
    check("s33_prime", 32'(state), 32'd1);
    cyc(0, 1, 6, "s33b");
    cyc(0, 1, 7, "s33c");
    cyc(0, 1, 8, "s33d");
    check("s33_state_up", 32'(state), 32'd2);
    check("s33_step3", 32'(step_cnt), 32'd3);
    check("s33_dir_up", 32'(dir_out), 32'd0);
    check("s33_locked", 32'(locked), 32'd1);

    // Up run across the wrap
    do_reset("s34r");
    wrap_seen = 0;
    cyc(0, 1, 62, "s34a");
    cyc(0, 1, 63, "s34b");
    check("s34_nowrap_before", 32'(wrap_seen), 32'd0);
    cyc(0, 1, 0, "s34c");
    check("s34_wrap_after0", 32'(wrap_pulse), 32'd1);
    cyc(0, 1, 1, "s34d");
    check("s34_wrap_once", 32'(wrap_seen), 32'd1);
    check("s34_step3", 32'(step_cnt), 32'd3);

    // Reversal
    do_reset("s35r");
    cyc(0, 1, 10, "s35a");
    cyc(0, 1, 11, "s35b");
    cyc(0, 1, 12, "s35c");
    cyc(0, 1, 11, "s35d");
    check("s35_rev", 32'(rev_pulse), 32'd1);
    check("s35_dir_down", 32'(dir_out), 32'd1);
    check("s35_step1", 32'(step_cnt), 32'd1);

    // Illegal jump and recovery
    do_reset("s36r");
    cyc(0, 1, 20, "s36a");
    cyc(0, 1, 21, "s36b");
    cyc(0, 1, 25, "s36c");
    check("s36_err", 32'(err_pulse), 32'd1);
    check("s36_fault", 32'(state), 32'd4);
    check("s36_dir_held", 32'(dir_out), 32'd0);
    cyc(0, 1, 26, "s36d");
    check("s36_prime", 32'(state), 32'd1);
    check("s36_err_once", 32'(err_pulse), 32'd0);
    cyc(0, 1, 27, "s36e");
    check("s36_up", 32'(state), 32'd2);
    check("s36_step1", 32'(step_cnt), 32'd1);

    // Down across zero with gaps and a repeat
    do_reset("s37r");
    wrap_seen = 0;
    cyc(0, 1, 0, "s37a");
    cyc(0, 0, 17, "s37g1");
    cyc(0, 0, 40, "s37g2");
    cyc(0, 1, 63, "s37b");
    check("s37_down", 32'(state), 32'd3);
    check("s37_wrap", 32'(wrap_pulse), 32'd1);
    cyc(0, 0, 5, "s37g3");
    cyc(0, 1, 63, "s37c");
    check("s37_repeat_step", 32'(step_cnt), 32'd1);
    cyc(0, 0, 9, "s37g4");
    check("s37_wrap_once", 32'(wrap_seen), 32'd1);
    check("s37_still_down", 32'(state), 32'd3);

    // Reset mid-run
    do_reset("s38r");
    for (int i = 10; i <= 14; i++) cyc(0, 1, i, "s38run");
    check("s38_step4", 32'(step_cnt), 32'd4);
    cyc(1, 1, 40, "s38rst");
    check("s38_rst_state", 32'(state), 32'd0);
    check("s38_rst_step", 32'(step_cnt), 32'd0);
    check("s38_rst_locked", 32'(locked), 32'd0);
    cyc(0, 1, 30, "s38a");
    check("s38_prime", 32'(state), 32'd1);
    cyc(0, 1, 29, "s38b");
    check("s38_down", 32'(state), 32'd3);
    check("s38_nowrap", 32'(wrap_pulse), 32'd0);

    // Saturation of the run-length counter
    do_reset("satr");
    cyc(0, 1, 0, "sat0");
    for (int i = 1; i <= SatMax + 40; i++) cyc(0, 1, i, "satrun");
    check("sat_max", 32'(step_cnt), 32'(SatMax));

    // Randomized traffic, mostly legal steps
    do_reset("rndr");
    for (int i = 0; i < 1500; i++) begin
      int pick;
      int x;
      pick = int'($urandom_range(0, 99));
      if (pick < 40) x = last_x + 1;
      else if (pick < 70) x = last_x - 1;
      else if (pick < 80) x = last_x;
      else x = int'($urandom_range(0, Mask));
      if (pick == 99) cyc(1, 1, x, "rnd");
      else cyc(0, ($urandom_range(0, 5) != 0), x, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
